// File: rtl/ahb_apb_pkg.sv
// ============================================================================
// Module : ahb_apb_pkg
// Brief  : Shared encodings and state type for the AHB-Lite to APB4 bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ahb_apb_strb_gen.sv
// ============================================================================
// Module : ahb_apb_strb_gen
// Brief  : Combinational byte-strobe decode from HSIZE and the low address bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ahb_apb_strb_gen
    import ahb_apb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o
);

    // Sizes wider than a word still cover the full APB word.
    always_comb begin
        strb_o = 4'hF;
        case (hsize_i)
            3'd0:    strb_o = 4'b0001 << addr_i;
            3'd1:    strb_o = 4'b0011 << {addr_i[1], 1'b0};
            default: strb_o = 4'hF;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ahblite_apb_bridge.sv
// ============================================================================
// Module : ahblite_apb_bridge
// Brief  : AHB-Lite slave forwarding each transfer to a multi-slave APB4 segment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ahblite_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int PSEL_W   = 4,
    parameter int PSEL_LSB = 16,
    parameter int NUM_PSLV = 9,
    parameter int PADDR_W  = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic                HREADY,
    input  logic [31:0]         HWDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    output logic [NUM_PSLV-1:0] PSEL,
    output logic                PENABLE,
    output logic [PADDR_W-1:0]  PADDR,
    output logic                PWRITE,
    output logic [31:0]         PWDATA,
    output logic [3:0]          PSTRB,
    input  logic [31:0]         PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q;
    logic                hreadyout_q;
    logic                hresp_q;
    logic [31:0]         hrdata_q;
    logic [NUM_PSLV-1:0] psel_q;
    logic                penable_q;
    logic [PADDR_W-1:0]  paddr_q;
    logic                pwrite_q;
    logic [3:0]          pstrb_q;
    logic [TMR_W-1:0]    timer_q;

    logic                w_accept;
    logic [PSEL_W-1:0]   w_idx;
    logic                w_mapped;
    logic [NUM_PSLV-1:0] w_onehot;
    logic [3:0]          w_strb;
    logic                w_unused;

    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_idx    = HADDR[PSEL_LSB +: PSEL_W];
    assign w_mapped = ({{(32-PSEL_W){1'b0}}, w_idx} < 32'(NUM_PSLV));
    assign w_unused = ^HADDR;

    generate
        for (genvar g = 0; g < NUM_PSLV; g++) begin : g_psel_dec
            assign w_onehot[g] = (w_idx == PSEL_W'(g));
        end
    endgenerate

    ahb_apb_strb_gen u_strb_gen (
        .hsize_i (HSIZE),
        .addr_i  (HADDR[1:0]),
        .strb_o  (w_strb)
    );

    // Output registers are loaded with the values of the state being entered,
    // so every bus output is glitch-free and aligned with state_q.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    penable_q <= 1'b0;
                    if (w_accept) begin
                        paddr_q     <= {HADDR[PADDR_W-1:2], 2'b00};
                        pwrite_q    <= HWRITE;
                        pstrb_q     <= HWRITE ? w_strb : 4'h0;
                        hreadyout_q <= 1'b0;
                        if (w_mapped) begin
                            state_q <= ST_SETUP;
                            psel_q  <= w_onehot;
                            hresp_q <= HRESP_OKAY;
                        end else begin
                            state_q  <= ST_ERR1;
                            psel_q   <= '0;
                            hresp_q  <= HRESP_ERROR;
                            hrdata_q <= UNMAPPED_RDATA;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        psel_q      <= '0;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    timer_q   <= '0;
                end
                ST_ACCESS: begin
                    timer_q <= timer_q + 1'b1;
                    if (PREADY) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (PSLVERR) begin
                            state_q <= ST_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end else begin
                            state_q     <= ST_DONE;
                            hreadyout_q <= 1'b1;
                            if (!pwrite_q) begin
                                hrdata_q <= PRDATA;
                            end
                        end
                    end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                        state_q   <= ST_ERR1;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        hresp_q   <= HRESP_ERROR;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                ST_ERR2: begin
                    // The master cancels whatever it presents here.
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PSTRB     = pstrb_q;
    assign PWDATA    = HWDATA;

endmodule

`default_nettype wire

// File: tb/tb_ahblite_apb_bridge.sv
// ============================================================================
// Module : tb_ahblite_apb_bridge
// Brief  : Randomized transaction-level bench for ahblite_apb_bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ahblite_apb_bridge;
    import ahb_apb_pkg::*;

    localparam int NUM_PSLV = 9;
    localparam int TIMEOUT  = 255;
    localparam int MAXC     = 3000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL, HWRITE, HREADY, PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, PRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, HRESP, PENABLE, PWRITE;
    logic [31:0] HRDATA, PWDATA;
    logic [8:0]  PSEL;
    logic [15:0] PADDR;
    logic [3:0]  PSTRB;

    always #5 HCLK = ~HCLK;

    ahblite_apb_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL),
        .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic hsel; logic [31:0] haddr; logic [1:0] htrans; logic hwrite;
        logic [2:0] hsize; logic hready; logic [31:0] hwdata;
        logic [31:0] prdata; logic pready; logic pslverr;
    } stim_t;

    typedef struct {
        logic rdy; logic resp; logic [31:0] hrdata; logic [8:0] psel; logic pen;
        logic [15:0] paddr; logic pwrite; logic [3:0] pstrb;
        logic chk_pwdata; logic [31:0] pwdata;
        logic upd; logic [31:0] updv;
    } exp_t;

    stim_t stim [MAXC];
    exp_t  expv [MAXC];
    logic        obs_rdy [MAXC], obs_resp [MAXC], obs_pen [MAXC];
    logic [8:0]  obs_psel [MAXC];
    logic [15:0] obs_paddr [MAXC];
    logic [3:0]  obs_pstrb [MAXC];
    logic [31:0] obs_hrdata [MAXC];

    int n_chk = 0;
    int n_fail = 0;
    int c = 0;
    int ncyc = 0;
    int k_cur = 0;
    logic run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [3:0] strb_of(input logic [2:0] sz, input logic [1:0] lo);
        int a;
        a = int'(lo);
        case (sz)
            3'd0:    return 4'(1 << a);
            3'd1:    return 4'(3 << (a & 2));
            default: return 4'hF;
        endcase
    endfunction

    task automatic make_ignored(input int k);
        if ($urandom_range(0, 1) == 1) begin
            stim[k].hsel   = 1'b1;
            stim[k].htrans = HTRANS_NONSEQ;
            stim[k].hready = 1'b1;
        end
    endtask

    // One AHB transfer: address phase at stim[a]; expected outputs follow from
    // the wait count, the error flag and whether the index is populated.
    task automatic plan(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic err, input int gap, output int a);
        int idx, n, e;
        logic tmo;
        idx = int'(addr[19:16]);
        c = c + gap;
        a = c;
        stim[a].hsel   = 1'b1;
        stim[a].htrans = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        stim[a].hready = 1'b1;
        stim[a].haddr  = addr;
        stim[a].hwrite = wr;
        stim[a].hsize  = sz;
        if (idx >= NUM_PSLV) begin
            expv[a].rdy = 1'b0; expv[a].resp = 1'b1;
            expv[a].upd = 1'b1; expv[a].updv = 32'hDEADBEEF;
            expv[a+1].resp = 1'b1;
            make_ignored(a + 2);
            c = a + 3;
        end else begin
            tmo = (waits >= TIMEOUT);
            n = tmo ? TIMEOUT : waits + 1;
            for (int k = a; k <= a + n; k++) begin
                expv[k].rdy = 1'b0;
                expv[k].psel = 9'(1 << idx);
                expv[k].pen = (k != a);
                expv[k].paddr = {addr[15:2], 2'b00};
                expv[k].pwrite = wr;
                expv[k].pstrb = wr ? strb_of(sz, addr[1:0]) : 4'h0;
                expv[k].chk_pwdata = wr && (k != a);
                expv[k].pwdata = wd;
            end
            for (int k = a + 1; k <= a + n + 1; k++) begin
                stim[k].hwdata = wd;
                stim[k].pready = 1'b0;
            end
            e = a + n + 1;
            if (!tmo) begin
                stim[e].pready = 1'b1;
                stim[e].pslverr = err;
                stim[e].prdata = rd;
            end
            if (tmo || err) begin
                expv[e].rdy = 1'b0; expv[e].resp = 1'b1;
                expv[e+1].resp = 1'b1;
                make_ignored(e + 2);
                c = e + 3;
            end else begin
                if (!wr) begin
                    expv[e].upd = 1'b1; expv[e].updv = rd;
                end
                c = e + 1;
            end
        end
    endtask

    function automatic int cnt_lo(input int a);
        int n = 0;
        while (a + n < MAXC - 1 && obs_rdy[a+n] == 1'b0) n++;
        return n;
    endfunction

    task automatic apply(input stim_t s);
        HSEL = s.hsel; HADDR = s.haddr; HTRANS = s.htrans; HWRITE = s.hwrite;
        HSIZE = s.hsize; HREADY = s.hready; HWDATA = s.hwdata;
        PRDATA = s.prdata; PREADY = s.pready; PSLVERR = s.pslverr;
    endtask

    task automatic drive_idle();
        HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = 3'd2;
        HREADY = 1'b1; HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    // Compare process: every planned cycle, outputs against the model.
    always @(posedge HCLK) begin
        if (run) begin
            int k;
            #1;
            k = k_cur;
            obs_rdy[k] = HREADYOUT; obs_resp[k] = HRESP; obs_pen[k] = PENABLE;
            obs_psel[k] = PSEL; obs_paddr[k] = PADDR; obs_pstrb[k] = PSTRB;
            obs_hrdata[k] = HRDATA;
            chk($sformatf("c%0d HREADYOUT", k), 32'(HREADYOUT), 32'(expv[k].rdy));
            chk($sformatf("c%0d HRESP", k), 32'(HRESP), 32'(expv[k].resp));
            chk($sformatf("c%0d HRDATA", k), HRDATA, expv[k].hrdata);
            chk($sformatf("c%0d PSEL", k), 32'(PSEL), 32'(expv[k].psel));
            chk($sformatf("c%0d PENABLE", k), 32'(PENABLE), 32'(expv[k].pen));
            if (expv[k].psel != 9'd0) begin
                chk($sformatf("c%0d PADDR", k), 32'(PADDR), 32'(expv[k].paddr));
                chk($sformatf("c%0d PWRITE", k), 32'(PWRITE), 32'(expv[k].pwrite));
                chk($sformatf("c%0d PSTRB", k), 32'(PSTRB), 32'(expv[k].pstrb));
            end
            if (expv[k].chk_pwdata)
                chk($sformatf("c%0d PWDATA", k), PWDATA, expv[k].pwdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, dummy;
        logic [31:0] cur;

        for (int k = 0; k < MAXC; k++) begin
            stim[k].hsel   = 1'($urandom_range(0, 1));
            stim[k].htrans = 2'($urandom_range(0, 3));
            stim[k].hready = 1'($urandom_range(0, 1));
            if (stim[k].htrans[1]) begin
                if ($urandom_range(0, 1) == 1) stim[k].hsel = 1'b0;
                else stim[k].hready = 1'b0;
            end
            stim[k].haddr   = $urandom;
            stim[k].hwrite  = 1'($urandom_range(0, 1));
            stim[k].hsize   = 3'($urandom_range(0, 2));
            stim[k].hwdata  = $urandom;
            stim[k].prdata  = $urandom;
            stim[k].pready  = 1'($urandom_range(0, 1));
            stim[k].pslverr = 1'($urandom_range(0, 1));
            expv[k].rdy = 1'b1; expv[k].resp = 1'b0; expv[k].hrdata = '0;
            expv[k].psel = '0; expv[k].pen = 1'b0; expv[k].paddr = '0;
            expv[k].pwrite = 1'b0; expv[k].pstrb = '0; expv[k].chk_pwdata = 1'b0;
            expv[k].pwdata = '0; expv[k].upd = 1'b0; expv[k].updv = '0;
        end

        plan(32'h40030008, 1'b1, 3'd2, 32'h12345678, 32'h0, 0, 1'b0, 1, a1);
        plan(32'h40010004, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 3, 1'b0, 1, a2);
        plan(32'h40020003, 1'b1, 3'd0, 32'hA5A5A5A5, 32'h0, 0, 1'b0, 1, a3);
        plan(32'h40020002, 1'b1, 3'd1, 32'h5A5A5A5A, 32'h0, 1, 1'b0, 1, a4);
        plan(32'h40050010, 1'b1, 3'd2, 32'h11112222, 32'h0, 0, 1'b1, 1, a5);
        plan(32'h400C0000, 1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0, 1, a6);
        plan(32'h40020020, 1'b0, 3'd2, 32'h0, 32'h33334444, 400, 1'b0, 1, a7);
        plan(32'h40040030, 1'b0, 3'd2, 32'h0, 32'h55556666, TIMEOUT - 1, 1'b0, 1, a8);
        plan(32'h40060040, 1'b0, 3'd2, 32'h0, 32'h77778888, 0, 1'b0, 1, a9);
        plan(32'h40070044, 1'b1, 3'd2, 32'h9999AAAA, 32'h0, 0, 1'b0, 0, a10);

        for (int i = 0; i < 70; i++) begin
            int idx, waits;
            logic [31:0] addr;
            if ($urandom_range(0, 3) == 0) idx = 9 + $urandom_range(0, 6);
            else idx = $urandom_range(0, 8);
            addr = {12'h400, 4'(idx), 16'($urandom)};
            waits = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 20) : $urandom_range(0, 2);
            plan(addr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), $urandom, $urandom,
                 waits, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), dummy);
        end
        ncyc = c + 4;

        cur = '0;
        for (int k = 0; k < ncyc; k++) begin
            if (expv[k].upd) cur = expv[k].updv;
            expv[k].hrdata = cur;
        end

        drive_idle();
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("reset HRESP", 32'(HRESP), 32'd0);
        chk("reset HRDATA", HRDATA, 32'd0);
        chk("reset PSEL", 32'(PSEL), 32'd0);
        chk("reset PENABLE", 32'(PENABLE), 32'd0);
        chk("reset PADDR", 32'(PADDR), 32'd0);
        chk("reset PWRITE", 32'(PWRITE), 32'd0);
        chk("reset PSTRB", 32'(PSTRB), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int k = 0; k < ncyc; k++) begin
            @(negedge HCLK);
            apply(stim[k]);
            k_cur = k;
            run = 1'b1;
        end
        @(negedge HCLK);
        run = 1'b0;
        drive_idle();

        chk("t1 wait cycles", 32'(cnt_lo(a1)), 32'd2);
        chk("t1 PSEL", 32'(obs_psel[a1]), 32'h008);
        chk("t1 PADDR", 32'(obs_paddr[a1]), 32'h0008);
        chk("t1 PSTRB", 32'(obs_pstrb[a1]), 32'hF);
        chk("t1 HRESP", 32'(obs_resp[a1+2]), 32'd0);
        chk("t2 wait cycles", 32'(cnt_lo(a2)), 32'd5);
        chk("t2 HRDATA", obs_hrdata[a2+5], 32'hCAFEF00D);
        chk("t3 byte PSTRB", 32'(obs_pstrb[a3]), 32'h8);
        chk("t3 half PSTRB", 32'(obs_pstrb[a4]), 32'hC);
        chk("t4 ERR1 HRESP", 32'(obs_resp[a5+2]), 32'd1);
        chk("t4 ERR1 HREADYOUT", 32'(obs_rdy[a5+2]), 32'd0);
        chk("t4 ERR2 HRESP", 32'(obs_resp[a5+3]), 32'd1);
        chk("t4 ERR2 HREADYOUT", 32'(obs_rdy[a5+3]), 32'd1);
        chk("t4 unmapped PSEL", 32'(obs_psel[a6]), 32'd0);
        chk("t4 unmapped HRESP", 32'(obs_resp[a6]), 32'd1);
        chk("t4 unmapped HRDATA", obs_hrdata[a6], 32'hDEADBEEF);
        begin
            int np = 0;
            while (np < 400 && obs_pen[a7+1+np] == 1'b1) np++;
            chk("t5 ACCESS cycles", 32'(np), 32'd255);
        end
        chk("t5 PSEL after timeout", 32'(obs_psel[a7+256]), 32'd0);
        chk("t5 HRESP after timeout", 32'(obs_resp[a7+256]), 32'd1);
        chk("t5 last-cycle PREADY wait", 32'(cnt_lo(a8)), 32'd256);
        chk("t5 last-cycle PREADY HRESP", 32'(obs_resp[a8+256]), 32'd0);
        chk("t6 DONE before b2b", 32'(obs_rdy[a10-1]), 32'd1);
        chk("t6 b2b SETUP PSEL", 32'(obs_psel[a10]), 32'h080);
        chk("t6 b2b SETUP PENABLE", 32'(obs_pen[a10]), 32'd0);

        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h40070010; HWRITE = 1'b0;
        HREADY = 1'b1; PREADY = 1'b0;
        @(negedge HCLK);
        drive_idle();
        @(posedge HCLK);
        #1;
        chk("rst pre PENABLE", 32'(PENABLE), 32'd1);
        chk("rst pre PSEL", 32'(PSEL), 32'h080);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst mid HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("rst mid HRESP", 32'(HRESP), 32'd0);
        chk("rst mid HRDATA", HRDATA, 32'd0);
        chk("rst mid PSEL", 32'(PSEL), 32'd0);
        chk("rst mid PENABLE", 32'(PENABLE), 32'd0);
        chk("rst mid PADDR", 32'(PADDR), 32'd0);
        chk("rst mid PSTRB", 32'(PSTRB), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("rst post HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("rst post PSEL", 32'(PSEL), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
